// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with stall, bubble, conflict flag and optional perf counters
// Optional feature macro: PIPE_PERF_CNT_EN (builds saturating stall/bubble cycle counters)
module pipe_stage_reg #(
  parameter int               WIDTH      = 64,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}},
  parameter int               CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             bubble,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] d_out,
  output logic             conflict,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             conflict_q, conflict_d;

  // Next-state selection: stall wins over bubble, bubble wins over a normal load
  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    conflict_d = conflict_q;
    if (stall) begin
      if (bubble) begin
        conflict_d = 1'b1;
      end
    end else if (bubble) begin
      data_d  = BUBBLE_VAL;
      valid_d = 1'b0;
    end else begin
      data_d  = d_in;
      valid_d = valid_in;
    end
  end

  // Stage register; reset discards any held contents and the sticky conflict flag
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= RESET_VAL;
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      conflict_q <= conflict_d;
    end
  end

  assign d_out     = data_q;
  assign valid_out = valid_q;
  assign conflict  = conflict_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters; a bubble masked by a stall counts only as a stall
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (bubble && !stall && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
